mesh_router_xy: RTL and testbench

Parametrised five-port mesh router, successor to the fixed 64-bit cardinal router. It keeps the even/odd virtual-channel (VC) phase scheme and adds three things: configurable data width, per-input FIFO depth per VC, and dimension-ordered XY routing computed from a destination field in each packet against the router's own (X_ID, Y_ID). One instance sits at every mesh node between four neighbour links and the local processing element (PE).

---
 rtl/mesh_router_xy_if.sv | 24 ++
 rtl/mesh_router_xy.sv | 151 +++++++++++++++
 tb/tb_mesh_router_xy.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesh_router_xy_if.sv
// Link bundle for the five-port XY mesh router: per-port send/ready/data in both directions,
// plus the phase indicator and VC-error pulses. Port index: 0 up, 1 down, 2 left, 3 right, 4 pe.
interface mesh_router_xy_if #(
  parameter int DW = 64
);
  logic [4:0]      in_s;
  logic [4:0]      in_r;
  logic [5*DW-1:0] in_d;
  logic [4:0]      out_s;
  logic [4:0]      out_r;
  logic [5*DW-1:0] out_d;
  logic [4:0]      err_vc;
  logic            polarity;

  modport master (
    output in_s, in_d, out_r,
    input  in_r, out_s, out_d, err_vc, polarity
  );

  modport slave (
    input  in_s, in_d, out_r,
    output in_r, out_s, out_d, err_vc, polarity
  );
endinterface

// File: rtl/mesh_router_xy.sv
// Five-port XY mesh router with even/odd VC phases; 2-cycle minimum latency (accept, arbitrate, send).
// Backpressure: a blocked output register stalls its VC FIFOs, and in_r drops once an input VC FIFO is full.
module mesh_router_xy #(
  parameter int DW        = 64,
  parameter int COORD_W   = 4,
  parameter int X_ID      = 0,
  parameter int Y_ID      = 0,
  parameter int BUF_DEPTH = 2
) (
  input logic             clk,
  input logic             reset,
  mesh_router_xy_if.slave link
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [COORD_W-1:0] MY_X     = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] MY_Y     = COORD_W'(Y_ID);
  localparam logic [2:0] P_UP = 3'd0, P_DOWN = 3'd1, P_LEFT = 3'd2, P_RIGHT = 3'd3, P_PE = 3'd4;

  logic            polarity_q;
  logic            ext_vc;
  logic [DW-1:0]   mem      [5][2][BUF_DEPTH];
  logic [CNT_W-1:0] cnt     [5][2];
  logic [PTR_W-1:0] rd_ptr  [5][2];
  logic [PTR_W-1:0] wr_ptr  [5][2];
  logic [DW-1:0]   out_data [5][2];
  logic [1:0]      out_full [5];
  logic [2:0]      rr       [5][2];
  logic [4:0]      err_q;

  logic [DW-1:0]   din       [5];
  logic [DW-1:0]   head      [5];
  logic [2:0]      head_port [5];
  logic [2:0]      gnt_idx   [5];
  logic [4:0]      push, pop, head_vld, in_rdy, snd, gnt_vld;
  logic [5*DW-1:0] out_bus;

  function automatic logic [2:0] route(input logic [2*COORD_W-1:0] dest);
    logic [COORD_W-1:0] dx, dy;
    dx = dest[2*COORD_W-1 -: COORD_W];
    dy = dest[COORD_W-1:0];
    if (dx > MY_X)      return P_RIGHT;
    else if (dx < MY_X) return P_LEFT;
    else if (dy > MY_Y) return P_DOWN;
    else if (dy < MY_Y) return P_UP;
    else                return P_PE;
  endfunction

  function automatic logic [2:0] add5(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Links carry the VC opposite to the one being arbitrated this cycle.
  assign ext_vc = ~polarity_q;

  for (genvar i = 0; i < 5; i++) begin : g_in
    assign din[i]       = link.in_d[i*DW +: DW];
    assign in_rdy[i]    = ~reset & (cnt[i][ext_vc] < DEPTH_C);
    assign push[i]      = link.in_s[i] & in_rdy[i];
    assign head[i]      = mem[i][polarity_q][rd_ptr[i][polarity_q]];
    assign head_vld[i]  = (cnt[i][polarity_q] != '0);
    assign head_port[i] = route(head[i][DW-2 -: 2*COORD_W]);
  end

  for (genvar o = 0; o < 5; o++) begin : g_out
    assign snd[o] = out_full[o][ext_vc] & link.out_r[o];
  end

  always_comb begin
    out_bus = '0;
    for (int o = 0; o < 5; o++) out_bus[o*DW +: DW] = out_data[o][ext_vc];
  end

  // Round-robin per output on the internal VC; each input has a single head so grants never collide.
  always_comb begin
    gnt_vld = '0;
    pop     = '0;
    for (int o = 0; o < 5; o++) begin
      gnt_idx[o] = '0;
      if (!out_full[o][polarity_q]) begin
        for (int k = 0; k < 5; k++) begin
          if (!gnt_vld[o] && head_vld[add5(rr[o][polarity_q], 3'(k))] &&
              head_port[add5(rr[o][polarity_q], 3'(k))] == 3'(o)) begin
            gnt_vld[o] = 1'b1;
            gnt_idx[o] = add5(rr[o][polarity_q], 3'(k));
          end
        end
      end
      if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      polarity_q <= 1'b0;
      err_q      <= '0;
      for (int i = 0; i < 5; i++) begin
        out_full[i] <= '0;
        for (int v = 0; v < 2; v++) begin
          cnt[i][v]      <= '0;
          rd_ptr[i][v]   <= '0;
          wr_ptr[i][v]   <= '0;
          out_data[i][v] <= '0;
          rr[i][v]       <= '0;
        end
      end
    end else begin
      polarity_q <= ~polarity_q;
      for (int i = 0; i < 5; i++) begin
        err_q[i] <= push[i] & (din[i][DW-1] != ext_vc);
        if (push[i]) begin
          wr_ptr[i][ext_vc] <= ptr_inc(wr_ptr[i][ext_vc]);
          cnt[i][ext_vc]    <= cnt[i][ext_vc] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr[i][polarity_q] <= ptr_inc(rd_ptr[i][polarity_q]);
          cnt[i][polarity_q]    <= cnt[i][polarity_q] - 1'b1;
        end
      end
      for (int o = 0; o < 5; o++) begin
        if (snd[o]) out_full[o][ext_vc] <= 1'b0;
        if (gnt_vld[o]) begin
          out_full[o][polarity_q] <= 1'b1;
          out_data[o][polarity_q] <= head[gnt_idx[o]];
          rr[o][polarity_q]       <= add5(gnt_idx[o], 3'd1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (push[i]) mem[i][ext_vc][wr_ptr[i][ext_vc]] <= din[i];
    end
  end

  assign link.in_r     = in_rdy;
  assign link.out_s    = snd;
  assign link.out_d    = out_bus;
  assign link.err_vc   = err_q;
  assign link.polarity = polarity_q;
endmodule

// File: tb/tb_mesh_router_xy.sv
// Bench for mesh_router_xy at node (1,1): directed scenarios plus random traffic, all cycles
// compared against a queue-based reference model of the router.
module tb_mesh_router_xy;
  localparam int DW = 64, DEPTH = 2, XI = 1, YI = 1;
  typedef logic [DW-1:0] pkt_t;

  logic clk = 1'b0;
  logic rst;
  mesh_router_xy_if #(.DW(DW)) bus();

  mesh_router_xy #(.DW(DW), .COORD_W(4), .X_ID(XI), .Y_ID(YI), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst), .link(bus.slave)
  );

  always #5 clk = ~clk;

  pkt_t       q[5][2][$];
  bit         m_full[5][2];
  pkt_t       m_data[5][2];
  int         m_rr[5][2];
  int         m_pol;
  logic [4:0] m_err;

  int n_chk = 0, n_fail = 0;
  bit armed = 1'b0;
  logic [4:0] s_out_s, s_in_r, s_err;
  logic [5*DW-1:0] s_out_d;
  logic s_pol;

  function automatic pkt_t pkt(input bit vc, input int dx, input int dy, input logic [54:0] pl);
    return {vc, 4'(dx), 4'(dy), pl};
  endfunction

  // XY: resolve column first, then row, else deliver locally.
  function automatic int mroute(input pkt_t d);
    int dx, dy;
    dx = int'(d[62:59]);
    dy = int'(d[58:55]);
    if (dx > XI) return 3;
    if (dx < XI) return 2;
    if (dy > YI) return 1;
    if (dy < YI) return 0;
    return 4;
  endfunction

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++)
      for (int v = 0; v < 2; v++) begin
        q[i][v].delete();
        m_full[i][v] = 1'b0;
        m_data[i][v] = '0;
        m_rr[i][v]   = 0;
      end
    m_pol = 0;
    m_err = '0;
  endtask

  task automatic model_update(input logic [4:0] acc_ok);
    int g[5];
    int p, e, i;
    pkt_t d;
    bit a;
    if (rst) begin
      model_reset();
      return;
    end
    p = m_pol;
    e = 1 - p;
    for (int o = 0; o < 5; o++) begin
      g[o] = -1;
      if (!m_full[o][p])
        for (int k = 0; k < 5; k++) begin
          i = (m_rr[o][p] + k) % 5;
          if (g[o] < 0 && q[i][p].size() > 0 && mroute(q[i][p][0]) == o) g[o] = i;
        end
    end
    for (int o = 0; o < 5; o++)
      if (m_full[o][e] && bus.out_r[o]) m_full[o][e] = 1'b0;
    for (int o = 0; o < 5; o++)
      if (g[o] >= 0) begin
        m_data[o][p] = q[g[o]][p].pop_front();
        m_full[o][p] = 1'b1;
        m_rr[o][p]   = (g[o] + 1) % 5;
      end
    for (int j = 0; j < 5; j++) begin
      d = bus.in_d[j*DW +: DW];
      a = bus.in_s[j] && acc_ok[j];
      m_err[j] = a && (d[DW-1] != e[0]);
      if (a) q[j][e].push_back(d);
    end
    m_pol = e;
  endtask

  // One clock: compare outputs mid-low-phase, then advance the model at the edge.
  task automatic step();
    logic [4:0] exp_in_r, exp_out_s;
    logic [5*DW-1:0] exp_out_d;
    int e;
    #1;
    e = 1 - m_pol;
    for (int i = 0; i < 5; i++) begin
      exp_in_r[i]  = !rst && (q[i][e].size() < DEPTH);
      exp_out_s[i] = m_full[i][e] && bus.out_r[i];
      exp_out_d[i*DW +: DW] = m_data[i][e];
    end
    if (armed) begin
      chk("polarity", 320'(bus.polarity), 320'(m_pol));
      chk("in_r", 320'(bus.in_r), 320'(exp_in_r));
      chk("err_vc", 320'(bus.err_vc), 320'(m_err));
      chk("out_s", 320'(bus.out_s), 320'(exp_out_s));
      chk("out_d", bus.out_d, exp_out_d);
    end
    s_out_s = bus.out_s;
    s_out_d = bus.out_d;
    s_in_r  = bus.in_r;
    s_err   = bus.err_vc;
    s_pol   = bus.polarity;
    @(posedge clk);
    model_update(exp_in_r);
    if (rst) armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_s = '0;
  endtask

  task automatic send(input int i, input pkt_t d);
    bus.in_s[i] = 1'b1;
    bus.in_d[i*DW +: DW] = d;
  endtask

  task automatic sync0();
    idle();
    while (m_pol != 0) step();
  endtask

  initial begin
    pkt_t pa, pu, pl, pm;
    pkt_t bp[3];
    pkt_t got[$];
    int hits[$];
    logic [4:0] orsum;

    model_reset();
    rst = 1'b1;
    bus.in_s = '0;
    bus.in_d = '0;
    bus.out_r = 5'h1F;

    // Reset held three cycles.
    step();
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_out_s", 320'(s_out_s), 320'(0));
      chk("rst_out_d", s_out_d, 320'(0));
      chk("rst_in_r", 320'(s_in_r), 320'(0));
      chk("rst_err", 320'(s_err), 320'(0));
    end
    rst = 1'b0;
    step();
    chk("post_rst_in_r", 320'(s_in_r), 320'(5'h1F));
    chk("post_rst_pol", 320'(s_pol), 320'(0));
    step();
    chk("pol_toggle", 320'(s_pol), 320'(1));

    // Route: PE to (2,1) goes right.
    sync0();
    pa = pkt(1'b1, 2, 1, 55'hA5);
    send(4, pa);
    step();
    idle();
    step();
    chk("route_err", 320'(s_err), 320'(0));
    step();
    chk("route_out_s", 320'(s_out_s), 320'(5'b01000));
    chk("route_out_d", 320'(s_out_d[3*DW +: DW]), 320'(pa));
    step();
    step();

    // Contention: up and left both to the local PE.
    sync0();
    pu = pkt(1'b1, 1, 1, 55'h111);
    pl = pkt(1'b1, 1, 1, 55'h222);
    send(0, pu);
    send(2, pl);
    step();
    idle();
    step();
    step();
    chk("cont_first_s", 320'(s_out_s), 320'(5'b10000));
    chk("cont_first_d", 320'(s_out_d[4*DW +: DW]), 320'(pu));
    step();
    chk("cont_gap_s", 320'(s_out_s), 320'(0));
    step();
    chk("cont_second_s", 320'(s_out_s), 320'(5'b10000));
    chk("cont_second_d", 320'(s_out_d[4*DW +: DW]), 320'(pl));
    chk("cont_rr_model", 320'(m_rr[4][1]), 320'(3));
    chk("cont_rr_dut", 320'(dut.rr[4][1]), 320'(3));
    step();

    // Backpressure on the PE output.
    bus.out_r = 5'b01111;
    sync0();
    for (int k = 0; k < 3; k++) begin
      bp[k] = pkt(1'b1, 1, 1, 55'(32'hB000 + k));
      send(0, bp[k]);
      step();
      idle();
      step();
    end
    step();
    chk("bp_in_r0", 320'(s_in_r[0]), 320'(0));
    chk("bp_out_s", 320'(s_out_s[4]), 320'(0));
    chk("bp_fifo_model", 320'(q[0][1].size()), 320'(2));
    chk("bp_reg_model", 320'(m_full[4][1]), 320'(1));
    bus.out_r = 5'h1F;
    for (int c = 0; c < 8; c++) begin
      step();
      if (s_out_s[4]) begin
        got.push_back(s_out_d[4*DW +: DW]);
        hits.push_back(c);
      end
    end
    chk("bp_count", 320'(got.size()), 320'(3));
    for (int k = 0; k < got.size() && k < 3; k++) chk("bp_order", 320'(got[k]), 320'(bp[k]));
    if (hits.size() == 3) begin
      chk("bp_gap1", 320'(hits[1] - hits[0]), 320'(2));
      chk("bp_gap2", 320'(hits[2] - hits[1]), 320'(2));
    end

    // VC mismatch from the down link.
    sync0();
    pm = pkt(1'b0, 1, 1, 55'h77);
    send(1, pm);
    step();
    idle();
    step();
    chk("vc_err_pulse", 320'(s_err), 320'(5'b00010));
    step();
    chk("vc_err_clear", 320'(s_err), 320'(0));
    chk("vc_out_s", 320'(s_out_s), 320'(5'b10000));
    chk("vc_out_d", 320'(s_out_d[4*DW +: DW]), 320'(pm));

    // Reset with four packets in flight.
    sync0();
    send(0, pkt(1'b1, 2, 1, 55'h1));
    send(1, pkt(1'b1, 0, 1, 55'h2));
    send(2, pkt(1'b1, 1, 2, 55'h3));
    send(3, pkt(1'b1, 1, 0, 55'h4));
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    orsum = '0;
    step();
    chk("midrst_in_r", 320'(s_in_r), 320'(5'h1F));
    for (int c = 0; c < 8; c++) begin
      step();
      orsum |= s_out_s;
    end
    chk("midrst_quiet", 320'(orsum), 320'(0));

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 5; i++) begin
        bus.in_s[i] = ($urandom_range(0, 9) < 4);
        bus.in_d[i*DW +: DW] = pkt(($urandom_range(0, 9) == 0) ? m_pol[0] : ~m_pol[0],
                                   $urandom_range(0, 3), $urandom_range(0, 3),
                                   55'({$urandom, $urandom}));
        bus.out_r[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
